// File: rtl/fsu_seq_pkg.sv
// Shared types and defaults for the FSU adder sequencer.
//   fsu_seq_state_t : sequencer state encoding
//   FSU_SLEN_W_DEF  : default stream-length / result width
//   FSU_BDEP_DEF    : default adder-tree pipeline latency
package fsu_seq_pkg;

  localparam int unsigned FSU_SLEN_W_DEF = 8;
  localparam int unsigned FSU_BDEP_DEF   = 2;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StDrain,
    StDone
  } fsu_seq_state_t;

endpackage

// File: rtl/bit_delay.sv
// Fixed-depth single-bit delay line with synchronous clear.
//   clk : clock
//   clr : synchronous clear of every stage
//   d   : input bit
//   q   : d delayed by DEPTH cycles (a plain wire when DEPTH is 0)
module bit_delay #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  if (DEPTH == 0) begin : g_wire
    assign q = d;
  end else begin : g_sr
    logic [DEPTH-1:0] sr_q;

    always_ff @(posedge clk) begin
      if (clr) begin
        sr_q <= '0;
      end else begin
        // Shift towards the MSB; written without slicing so DEPTH = 1 works.
        sr_q <= (sr_q << 1) | DEPTH'(d);
      end
    end

    assign q = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/fsu_add_seq.sv
// Sequencer for one FSU bitstream adder. Each accepted request clears the
// adder accumulator, enables the bitstream sources for slen cycles, drains the
// adder pipeline and returns the number of '1's seen on add_bit over the
// pipeline-aligned window.
//   clk     : clock
//   rst     : synchronous active-high reset
//   start   : run request, only honoured in idle
//   slen    : stream length, latched with start
//   abort   : cancel the run in progress
//   add_bit : adder output bit
//   busy    : high whenever not idle
//   clr     : one-cycle accumulator clear
//   src_en  : bitstream source enable
//   done    : one-cycle completion pulse
//   result  : '1' count of the last run
module fsu_add_seq
  import fsu_seq_pkg::*;
#(
  parameter int unsigned SLEN_W = FSU_SLEN_W_DEF,
  parameter int unsigned BDEP   = FSU_BDEP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SLEN_W-1:0] slen,
  input  logic              abort,
  input  logic              add_bit,
  output logic              busy,
  output logic              clr,
  output logic              src_en,
  output logic              done,
  output logic [SLEN_W-1:0] result
);

  // The cycle counter is shared by RUN and DRAIN, so it must hold both ranges.
  localparam int unsigned BdepW = $clog2(BDEP + 1);
  localparam int unsigned CntW  = (SLEN_W > BdepW) ? SLEN_W : BdepW;
  localparam logic [CntW-1:0] DrainLast = CntW'((BDEP == 0) ? 0 : BDEP - 1);
  localparam fsu_seq_state_t AfterRun = (BDEP == 0) ? StDone : StDrain;

  fsu_seq_state_t    state_q;
  logic [SLEN_W-1:0] len_q;
  logic [CntW-1:0]   cnt_q;
  logic [SLEN_W-1:0] result_q;
  logic              in_run;
  logic              abort_hit;
  logic              cap_en;

  assign in_run    = (state_q == StClear) || (state_q == StRun) || (state_q == StDrain);
  assign abort_hit = abort && in_run;

  // Outputs decode the registered state only.
  assign busy   = (state_q != StIdle);
  assign clr    = (state_q == StClear);
  assign src_en = (state_q == StRun);
  assign done   = (state_q == StDone);
  assign result = result_q;

  // cap_en marks the cycles where add_bit carries bits launched under src_en.
  bit_delay #(
    .DEPTH(BDEP)
  ) u_cap_delay (
    .clk(clk),
    .clr(rst || abort_hit),
    .d  (src_en),
    .q  (cap_en)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      len_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (abort_hit) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      if (cap_en && add_bit) begin
        result_q <= result_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            len_q   <= slen;
            state_q <= StClear;
          end
        end
        StClear: begin
          cnt_q    <= '0;
          result_q <= '0;
          if (len_q != '0) begin
            state_q <= StRun;
          end else begin
            state_q <= AfterRun;
          end
        end
        StRun: begin
          if (cnt_q == CntW'(len_q - 1'b1)) begin
            cnt_q   <= '0;
            state_q <= AfterRun;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDrain: begin
          if (cnt_q == DrainLast) begin
            cnt_q   <= '0;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsu_add_seq.sv
// Bench for fsu_add_seq: a BDEP=2 and a BDEP=0 instance share all inputs.
// A position-based model (cycles since start) predicts every output each cycle.
module tb_fsu_add_seq;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         abort;
  logic         add_bit;
  logic [W-1:0] slen;
  logic [1:0]   busy_v, clr_v, src_v, done_v;
  logic [W-1:0] res_v [2];

  int bdep [2] = '{2, 0};

  always #5 clk = ~clk;

  fsu_add_seq #(.SLEN_W(W), .BDEP(2)) dut_b2 (
    .clk(clk), .rst(rst), .start(start), .slen(slen), .abort(abort), .add_bit(add_bit),
    .busy(busy_v[0]), .clr(clr_v[0]), .src_en(src_v[0]), .done(done_v[0]), .result(res_v[0])
  );

  fsu_add_seq #(.SLEN_W(W), .BDEP(0)) dut_b0 (
    .clk(clk), .rst(rst), .start(start), .slen(slen), .abort(abort), .add_bit(add_bit),
    .busy(busy_v[1]), .clr(clr_v[1]), .src_en(src_v[1]), .done(done_v[1]), .result(res_v[1])
  );

  int n_chk = 0;
  int n_err = 0;
  int ecnt  = 0;
  int t0    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model: a run is a position counter; position 1 is the clear cycle,
  // 2..1+L source-enable, done at 2+L+B, capture window 2+B..1+L+B.
  bit m_valid = 1'b0;
  bit m_act [2];
  int m_pos [2];
  int m_len [2];
  int m_res [2];

  always @(posedge clk) begin
    ecnt++;
    for (int i = 0; i < 2; i++) begin
      int b;
      int p;
      b = bdep[i];
      p = m_pos[i];
      if (rst) begin
        m_act[i] = 1'b0;
        m_res[i] = 0;
      end else if (m_act[i]) begin
        if (abort && p <= 1 + m_len[i] + b) begin
          m_act[i] = 1'b0;
          m_res[i] = 0;
        end else begin
          if (p == 1) m_res[i] = 0;
          else if (add_bit && p >= 2 + b && p <= 1 + m_len[i] + b) m_res[i]++;
          if (p == 2 + m_len[i] + b) m_act[i] = 1'b0;
          else m_pos[i] = p + 1;
        end
      end else if (start) begin
        m_act[i] = 1'b1;
        m_pos[i] = 1;
        m_len[i] = int'(slen);
      end
    end
    if (rst) m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < 2; i++) begin
        int p;
        int l;
        p = m_pos[i];
        l = m_len[i];
        chk($sformatf("busy[%0d]", i), 32'(busy_v[i]), 32'(m_act[i]));
        chk($sformatf("clr[%0d]", i), 32'(clr_v[i]), 32'(m_act[i] && p == 1));
        chk($sformatf("src_en[%0d]", i), 32'(src_v[i]), 32'(m_act[i] && p >= 2 && p <= 1 + l));
        chk($sformatf("done[%0d]", i), 32'(done_v[i]), 32'(m_act[i] && p == 2 + l + bdep[i]));
        chk($sformatf("result[%0d]", i), 32'(res_v[i]), 32'(m_res[i]));
      end
    end
  end

  int done_p [2];
  int src_n  [2];
  int clr_p  [2];
  int res_d  [2];

  // Called at a negedge with the DUT idle; returns at position 1 of the run.
  task automatic launch(input int len);
    slen  = W'(len);
    start = 1'b1;
    t0    = ecnt + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives add_bit per position and records events until both instances finish.
  task automatic watch(input int bound, input bit ones, input logic [63:0] mask);
    for (int i = 0; i < 2; i++) begin
      done_p[i] = -1;
      src_n[i]  = 0;
      clr_p[i]  = -1;
      res_d[i]  = -1;
    end
    for (int k = 0; k < bound; k++) begin
      int p;
      p = ecnt - t0 + 1;
      add_bit = ones ? 1'b1 : ((p < 64) ? mask[p] : 1'b0);
      for (int i = 0; i < 2; i++) begin
        if (clr_v[i] && clr_p[i] < 0) clr_p[i] = p;
        if (src_v[i]) src_n[i]++;
        if (done_v[i] && done_p[i] < 0) begin
          done_p[i] = p;
          res_d[i]  = int'(res_v[i]);
        end
      end
      if (done_p[0] >= 0 && done_p[1] >= 0) break;
      @(negedge clk);
    end
    add_bit = 1'b0;
  endtask

  initial begin
    int nd [2];
    int d1 [2];
    int d2 [2];
    int ndone;

    rst = 1'b1; start = 1'b0; abort = 1'b0; add_bit = 1'b0; slen = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy_v), 32'd0);
    chk("reset done", 32'(done_v), 32'd0);
    chk("reset result", 32'(res_v[0]), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Full-ones stream of 16.
    launch(16);
    watch(40, 1'b1, '0);
    chk("t1 clr pos b2", clr_p[0], 1);
    chk("t1 src cycles b2", src_n[0], 16);
    chk("t1 done pos b2", done_p[0], 20);
    chk("t1 result b2", res_d[0], 16);
    chk("t1 src cycles b0", src_n[1], 16);
    chk("t1 done pos b0", done_p[1], 18);
    chk("t1 result b0", res_d[1], 16);
    repeat (2) @(negedge clk);

    // Bits just outside the BDEP=2 window must be ignored.
    launch(10);
    watch(40, 1'b0, 64'h0000_0000_0000_d12c);  // positions 2,3,5,8,12,14,15
    chk("t2 result b2", res_d[0], 3);
    chk("t2 done pos b2", done_p[0], 14);
    chk("t2 result b0", res_d[1], 4);
    repeat (3) @(negedge clk);

    // Zero-length stream.
    launch(0);
    watch(20, 1'b1, '0);
    chk("t3 done pos b0", done_p[1], 2);
    chk("t3 done pos b2", done_p[0], 4);
    chk("t3 src b0", src_n[1], 0);
    chk("t3 src b2", src_n[0], 0);
    chk("t3 result b0", res_d[1], 0);
    chk("t3 result b2", res_d[0], 0);
    repeat (2) @(negedge clk);

    // start held high: back-to-back runs, one idle cycle apart.
    nd = '{0, 0};
    d1 = '{-1, -1};
    d2 = '{-1, -1};
    slen = W'(8); add_bit = 1'b1; start = 1'b1; t0 = ecnt + 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (done_v[i]) begin
          if (nd[i] == 0) d1[i] = ecnt;
          else if (nd[i] == 1) d2[i] = ecnt;
          nd[i]++;
        end
      end
    end
    start = 1'b0;
    repeat (20) @(negedge clk);
    add_bit = 1'b0;
    chk("t4 done count b2", nd[0], 3);
    chk("t4 done count b0", nd[1], 3);
    chk("t4 first done b2", d1[0] - t0, 11);
    chk("t4 spacing b2", d2[0] - d1[0], 13);
    chk("t4 spacing b0", d2[1] - d1[1], 11);

    // Abort in the 5th source-enable cycle.
    add_bit = 1'b1;
    launch(20);
    repeat (5) @(negedge clk);
    chk("t5 partial b2", 32'(res_v[0]), 32'd2);
    chk("t5 partial b0", 32'(res_v[1]), 32'd4);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5 busy after abort", 32'(busy_v), 32'd0);
    chk("t5 result after abort b2", 32'(res_v[0]), 32'd0);
    chk("t5 result after abort b0", 32'(res_v[1]), 32'd0);
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (done_v != 2'b00) ndone++;
    end
    chk("t5 no done after abort", ndone, 0);
    launch(5);
    watch(30, 1'b1, '0);
    chk("t5 rerun result b2", res_d[0], 5);
    chk("t5 rerun done pos b2", done_p[0], 9);
    chk("t5 rerun result b0", res_d[1], 5);
    repeat (2) @(negedge clk);

    // Reset while the BDEP=2 instance drains.
    add_bit = 1'b1;
    launch(6);
    repeat (7) @(negedge clk);
    chk("t6 in drain busy", 32'(busy_v[0]), 32'd1);
    chk("t6 in drain src_en", 32'(src_v[0]), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6 busy after rst", 32'(busy_v), 32'd0);
    chk("t6 clr after rst", 32'(clr_v), 32'd0);
    chk("t6 src_en after rst", 32'(src_v), 32'd0);
    chk("t6 done after rst", 32'(done_v), 32'd0);
    chk("t6 result after rst b2", 32'(res_v[0]), 32'd0);
    launch(4);
    watch(30, 1'b1, '0);
    chk("t6 rerun result b2", res_d[0], 4);
    chk("t6 rerun done pos b2", done_p[0], 8);
    chk("t6 rerun result b0", res_d[1], 4);
    chk("t6 rerun done pos b0", done_p[1], 6);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

endmodule

// File: doc/fsu_add_seq.md
# fsu_add_seq

Sequencer for one FSU bitstream adder (parallel counter plus offset accumulator). Runs one stream window per request: clears the adder's accumulator, enables the upstream bitstream generators for a programmable number of cycles, and drains the adder-tree pipeline. It counts the '1's on the adder output bit over the aligned window and returns the binary count with a done pulse. It sits between the layer-level controller and each FSU adder instance.

## Interface
- `SLEN_W`, default 8: width of the stream-length field and of the result count.
- `BDEP`, default 2: pipeline latency, in cycles, from the adder's input bits to its `oBit`. `BDEP` = 0 is legal.

Ports:
- `clk`, in, 1: single clock; all logic is on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: request a run; sampled only in IDLE.
- `slen`, in, `SLEN_W`: stream length in cycles; latched when `start` is accepted.
- `abort`, in, 1: cancel the run in progress.
- `add_bit`, in, 1: the adder's `oBit`.
- `busy`, out, 1: high in every state except IDLE.
- `clr`, out, 1: one-cycle clear to the adder accumulator.
- `src_en`, out, 1: enable to the bitstream generators and RNGs.
- `done`, out, 1: one-cycle completion pulse.
- `result`, out, `SLEN_W`: count of '1's on `add_bit` over the window.

## Operation
- FSM states: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE:
  - `start`=1 latches `slen` into `len_q` and moves to CLEAR.
  - `start` in any other state is ignored and never queued.
- CLEAR (1 cycle):
  - `clr`=1; `result` and the cycle counter are zeroed.
  - Next state is RUN if `len_q`≠0. Otherwise DRAIN, or DONE if `BDEP`=0.
- RUN (`len_q` cycles):
  - `src_en`=1; the cycle counter increments each cycle.
  - Leaves for DRAIN (or DONE if `BDEP`=0) on the cycle the counter reaches `len_q`−1.
- DRAIN (`BDEP` cycles):
  - `src_en`=0; waits for the tail of the pipeline to emerge.
- DONE (1 cycle): `done`=1, then IDLE.
- Capture window:
  - `cap_en` = `src_en` delayed by exactly `BDEP` cycles.
  - `result` increments on each cycle where `cap_en`=1 and `add_bit`=1.
  - `add_bit` is ignored outside the window, so stale pipeline contents are never counted.
- Arithmetic: the count is at most `len_q` ≤ 2^`SLEN_W`−1, so overflow cannot occur and there is no saturation logic.
- `result` holds its final value from DONE until the next CLEAR.
- `abort`:
  - In CLEAR, RUN or DRAIN, next state is IDLE; no `done`; `result` is forced to 0; the delay line is flushed.
  - Ignored in IDLE and DONE.
- Simultaneous events:
  - `abort` takes priority over the state's normal transition.
  - `rst` takes priority over everything.
- Reset, including mid-run: state IDLE, `busy`=`clr`=`src_en`=`done`=0, `result`=0, delay line cleared.

## Timing
- `start` is sampled at edge T0. CLEAR occupies T0+1, RUN occupies T0+2 … T0+1+`len_q`, DRAIN follows, and `done` is high in cycle T0+2+`len_q`+`BDEP`.
- `busy` is high for exactly `len_q`+`BDEP`+2 cycles per completed run.
- `clr` and the first `src_en` cycle are back-to-back, so the accumulator is zero when the first valid input bit arrives.
- `result` is final in the DONE cycle. It changes no later than the edge that enters DONE.
- Minimum start-to-start spacing is `len_q`+`BDEP`+3 cycles: IDLE is visited for at least 1 cycle between runs.
- All outputs are registered or derived from state only; there are no combinational paths from inputs to outputs.

## Structure
- Package `fsu_seq_pkg` holds:
  - the state enum typedef `fsu_seq_state_t` (IDLE, CLEAR, RUN, DRAIN, DONE);
  - default parameter constants `FSU_SLEN_W_DEF`=8 and `FSU_BDEP_DEF`=2.
- One sub-module, `bit_delay`: a `BDEP`-deep shift register with synchronous clear, used to generate `cap_en`. At depth 0 it is a wire.
- Everything else is a single FSM plus two counters: the cycle counter and the result counter.

## Test plan
- `slen`=16, `BDEP`=2, `add_bit` tied 1 → `clr` pulses at T0+1, `src_en` is high 16 cycles, `done` at T0+20, `result`=16.
- `slen`=10, `BDEP`=2, `add_bit` high only in the 2 cycles before the window and 2 cycles after it, plus 3 cycles inside → `result`=3; out-of-window bits are not counted.
- `slen`=0, `BDEP`=0 → CLEAR then DONE; `done` at T0+2, `result`=0, `src_en` never asserted.
- `start` held high for 40 cycles with `slen`=8 → back-to-back runs with exactly one IDLE cycle between them; mid-run `start` is ignored.
- `abort` in the 5th RUN cycle of `slen`=20 → IDLE next cycle, no `done`, `result`=0. A new run then completes normally.
- `rst` asserted in DRAIN → all outputs 0 next cycle; a following run with `slen`=4 and `add_bit`=1 gives `result`=4.
